// File: rtl/mx_block_encoder.sv
`default_nettype none
// mx_block_encoder: gathers BLK FP32 values, derives one E8M0 scale, then streams MX elements.
// Optional macro MX_ENC_RNE_EN selects round-to-nearest-even quantization; truncation otherwise.
module mx_block_encoder #(
  parameter int BLK   = 32,
  parameter int CNT_W = $clog2(BLK)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  prec_mode,
  input  logic [1:0]  FP_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [22:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  out_scale,
  output logic        out_first,
  output logic        out_last
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    EMIT    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    F_INT8 = 3'd0,
    F_E4M3 = 3'd1,
    F_E5M2 = 3'd2,
    F_E3M2 = 3'd3,
    F_E2M3 = 3'd4,
    F_E2M1 = 3'd5
  } fmt_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK - 1);

  state_e           state_q, state_d;
  fmt_e             fmt_q, fmt_d, fmt_in;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       max_exp_q, max_exp_d;
  logic             nan_q, nan_d;
  logic [7:0]       scale_q, scale_d;
  logic [31:0]      buf_q [BLK];
  logic             in_beat;

  // Per-format constants: mantissa bits, exponent bias, element emax, max finite code, sign position.
  logic [2:0] f_m;
  logic [4:0] f_bias;
  logic [3:0] f_emax;
  logic [6:0] f_maxc;
  logic [2:0] f_spos;

  always_comb begin
    fmt_in = F_INT8;
    if (prec_mode == 2'b11) begin
      fmt_in = F_E2M1;
    end else if (prec_mode == 2'b01) begin
      case (FP_mode)
        2'b10:   fmt_in = F_E4M3;
        2'b11:   fmt_in = F_E5M2;
        2'b01:   fmt_in = F_E3M2;
        default: fmt_in = F_E2M3;
      endcase
    end
  end

  always_comb begin
    f_m = 3'd6; f_bias = 5'd1; f_emax = 4'd0; f_maxc = 7'd127; f_spos = 3'd7;
    case (fmt_q)
      F_E4M3:  begin f_m = 3'd3; f_bias = 5'd7;  f_emax = 4'd8;  f_maxc = 7'h7E; f_spos = 3'd7; end
      F_E5M2:  begin f_m = 3'd2; f_bias = 5'd15; f_emax = 4'd15; f_maxc = 7'h7B; f_spos = 3'd7; end
      F_E3M2:  begin f_m = 3'd2; f_bias = 5'd3;  f_emax = 4'd4;  f_maxc = 7'h1F; f_spos = 3'd5; end
      F_E2M3:  begin f_m = 3'd3; f_bias = 5'd1;  f_emax = 4'd2;  f_maxc = 7'h1F; f_spos = 3'd5; end
      F_E2M1:  begin f_m = 3'd1; f_bias = 5'd1;  f_emax = 4'd2;  f_maxc = 7'h07; f_spos = 3'd3; end
      default: begin f_m = 3'd6; f_bias = 5'd1;  f_emax = 4'd0;  f_maxc = 7'd127; f_spos = 3'd7; end
    endcase
  end

  logic [31:0]        cur;
  logic signed [10:0] eb;
  logic [5:0]         sh;
  logic [5:0]         expf;
  logic [55:0]        shv;
  logic [6:0]         q;
  logic [15:0]        code;
  logic [7:0]         qdata;
`ifdef MX_ENC_RNE_EN
  logic               guard;
  logic               sticky;
`endif

  // INT8 reuses the FP path as a 6-bit-mantissa format with bias 1, so overflow shows up as code > 127.
  always_comb begin
    cur  = buf_q[idx_q];
    eb   = $signed({3'b0, cur[30:23]}) - $signed({3'b0, scale_q}) + $signed({6'b0, f_bias});
    sh   = 6'd0;
    expf = 6'd0;
    if (eb < 11'sd1) begin
      sh = (eb < -11'sd39) ? 6'd40 : 6'(11'sd1 - eb);
    end else begin
      expf = (eb > 11'sd40) ? 6'd39 : 6'(eb - 11'sd1);
    end
    shv  = {1'b1, cur[22:0], 32'd0} >> sh;
    q    = 7'(shv >> (6'd55 - {3'b0, f_m}));
    code = (16'(expf) << f_m) + 16'(q);
`ifdef MX_ENC_RNE_EN
    guard  = shv[6'd54 - {3'b0, f_m}];
    sticky = |(shv & ((56'd1 << (6'd54 - {3'b0, f_m})) - 56'd1));
    code   = code + 16'(guard & (sticky | q[0]));
`endif
    if (code > 16'(f_maxc)) begin
      code = 16'(f_maxc);
    end
    qdata = 8'd0;
    if (!nan_q && cur[30:23] != 8'd0) begin
      if (fmt_q == F_INT8) begin
        qdata = cur[31] ? (8'd0 - code[7:0]) : code[7:0];
      end else begin
        qdata = code[7:0] | ({7'd0, cur[31]} << f_spos);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    fmt_d     = fmt_q;
    idx_d     = idx_q;
    max_exp_d = max_exp_q;
    nan_d     = nan_q;
    scale_d   = scale_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_scale = scale_q;
    in_beat   = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        in_beat  = in_valid;
        if (in_valid) begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == '0) begin
            fmt_d = fmt_in;
          end
          if (in_exp == 8'hFF) begin
            nan_d = 1'b1;
          end else if (in_exp > max_exp_q) begin
            max_exp_d = in_exp;
          end
          if (idx_q == LAST_IDX) begin
            state_d = SCALE;
            idx_d   = '0;
          end
        end
      end
      SCALE: begin
        if (nan_q) begin
          scale_d = 8'hFF;
        end else if (max_exp_q <= {4'd0, f_emax}) begin
          scale_d = 8'd0;
        end else begin
          scale_d = max_exp_q - {4'd0, f_emax};
        end
        state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = qdata;
        out_first = (idx_q == '0);
        out_last  = (idx_q == LAST_IDX);
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d   = COLLECT;
            idx_d     = '0;
            max_exp_d = 8'd0;
            nan_d     = 1'b0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= COLLECT;
      fmt_q     <= F_INT8;
      idx_q     <= '0;
      max_exp_q <= 8'd0;
      nan_q     <= 1'b0;
      scale_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      fmt_q     <= fmt_d;
      idx_q     <= idx_d;
      max_exp_q <= max_exp_d;
      nan_q     <= nan_d;
      scale_q   <= scale_d;
    end
  end

  // Element storage needs no reset: every slot is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (in_beat) begin
      buf_q[idx_q] <= {in_sign, in_exp, in_mant};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mx_block_encoder.sv
`default_nettype none
// tb_mx_block_encoder: directed and random MX blocks checked against a real-valued quantization model.
module tb_mx_block_encoder;
  localparam int BLK = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  prec_mode = 2'b00;
  logic [1:0]  FP_mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [22:0] in_mant = 23'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [7:0]  out_scale;
  logic        out_first;
  logic        out_last;

  mx_block_encoder #(.BLK(BLK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prec_mode(prec_mode), .FP_mode(FP_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_scale(out_scale), .out_first(out_first), .out_last(out_last)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] s;
    logic       f;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ready_mode = 0;
  logic [31:0] blk_w [BLK];

  // Format tables indexed 0 INT8, 1 E4M3, 2 E5M2, 3 E3M2, 4 E2M3, 5 E2M1.
  int M_T    [6] = '{6, 3, 2, 2, 3, 1};
  int BIAS_T [6] = '{0, 7, 15, 3, 1, 1};
  int EMAX_T [6] = '{0, 8, 15, 4, 2, 2};
  int MAXC_T [6] = '{127, 126, 123, 31, 31, 7};
  int SPOS_T [6] = '{7, 7, 7, 5, 5, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired before completion at %0t", name, $time);
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic int fmt_of(input logic [1:0] p, input logic [1:0] f);
    if (p == 2'b11) return 5;
    if (p == 2'b01) begin
      case (f)
        2'b10:   return 1;
        2'b11:   return 2;
        2'b01:   return 3;
        default: return 4;
      endcase
    end
    return 0;
  endfunction

  function automatic real code_val(input int fmt, input int c);
    int ef, mf;
    real den;
    if (fmt == 0) return c / 64.0;
    den = real'(1 << M_T[fmt]);
    ef  = c >> M_T[fmt];
    mf  = c & ((1 << M_T[fmt]) - 1);
    if (ef == 0) return (mf / den) * pow2(1 - BIAS_T[fmt]);
    return (1.0 + mf / den) * pow2(ef - BIAS_T[fmt]);
  endfunction

  // Pick the representable magnitude by exhaustive search over all finite codes.
  function automatic logic [7:0] model_quant(input int fmt, input int scale, input logic [31:0] w);
    real x, v;
    int  best;
`ifdef MX_ENC_RNE_EN
    real d, bd;
`endif
    if (w[30:23] == 8'd0) return 8'd0;
    x = (1.0 + w[22:0] / 8388608.0) * pow2(int'(w[30:23]) - scale);
    best = 0;
`ifdef MX_ENC_RNE_EN
    bd = x;
`endif
    for (int c = 1; c <= MAXC_T[fmt]; c++) begin
      v = code_val(fmt, c);
`ifdef MX_ENC_RNE_EN
      d = (x > v) ? x - v : v - x;
      if (d < bd || (d == bd && (c % 2) == 0)) begin
        best = c;
        bd   = d;
      end
`else
      if (v <= x) best = c;
`endif
    end
    if (fmt == 0) return w[31] ? 8'((256 - best) % 256) : 8'(best);
    return 8'(best) | (8'(w[31]) << SPOS_T[fmt]);
  endfunction

  function automatic int model_scale(input int fmt, output bit nan);
    int mx = 0;
    nan = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      if (blk_w[i][30:23] == 8'hFF) nan = 1'b1;
      else if (int'(blk_w[i][30:23]) > mx) mx = int'(blk_w[i][30:23]);
    end
    if (nan) return 255;
    if (mx == 0 || mx - EMAX_T[fmt] < 0) return 0;
    if (mx - EMAX_T[fmt] > 254) return 254;
    return mx - EMAX_T[fmt];
  endfunction

  task automatic push_expect(input int fmt);
    bit   nan;
    int   s;
    exp_t e;
    s = model_scale(fmt, nan);
    for (int i = 0; i < BLK; i++) begin
      e.d = nan ? 8'd0 : model_quant(fmt, s, blk_w[i]);
      e.s = 8'(s);
      e.f = (i == 0);
      e.l = (i == BLK - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    logic r;
    int   n = 0;
    forever begin
      @(negedge clk_i);
      r = in_ready;
      @(posedge clk_i);
      n++;
      if (r) break;
      if (n > 3000) begin
        fail("accept_timeout");
        break;
      end
    end
    #1;
  endtask

  task automatic send_elem(input logic [31:0] w);
    in_valid = 1'b1;
    {in_sign, in_exp, in_mant} = w;
    wait_accept();
  endtask

  task automatic send_block(input logic [1:0] p, input logic [1:0] f, input bit gaps);
    for (int i = 0; i < BLK; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk_i);
        #1;
      end
      if (i == 0) begin
        prec_mode = p;
        FP_mode   = f;
      end else begin
        prec_mode = 2'($urandom);
        FP_mode   = 2'($urandom);
      end
      send_elem(blk_w[i]);
    end
    in_valid = 1'b0;
    {in_sign, in_exp, in_mant} = 32'hDEAD_BEEF;
    push_expect(fmt_of(p, f));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rnd_word(input int base);
    int          t;
    logic [22:0] m;
    logic        s;
    m = 23'($urandom);
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) m = m & 23'h7E0000;
    if ($urandom_range(0, 15) == 0) return {s, 8'd0, m};
    t = base - int'($urandom_range(0, 20));
    if (t < 1) t = 1;
    if (t > 254) t = 254;
    return {s, 8'(t), m};
  endfunction

  task automatic fill_random(input int base, input bit allow_nan);
    int k;
    for (int i = 0; i < BLK; i++) blk_w[i] = rnd_word(base);
    if (allow_nan && $urandom_range(0, 7) == 0) begin
      k = int'($urandom_range(0, BLK - 1));
      blk_w[k][30:23] = 8'hFF;
    end
  endtask

  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          rcnt++;
          out_ready = (rcnt % 3 == 0);
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every output cycle is checked against the head of the expectation queue.
  initial begin
    exp_t e;
    bit   chk_next = 1'b0;
    forever begin
      @(negedge clk_i);
      if (chk_next) begin
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        chk_next = 1'b0;
      end
      if (rst_i) begin
        check("reset_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check("out_data_scale_first_last", 32'({out_data, out_scale, out_first, out_last}),
                32'({e.d, e.s, e.f, e.l}));
          check("in_ready_during_emit", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (out_last) chk_next = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    bit nan;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_scale", 32'(out_scale), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    #2 rst_i = 1'b0;

    // Hand-computed values pinning the model.
    check("pin_e4m3_one", 32'(model_quant(1, 119, {1'b0, 8'd127, 23'd0})), 32'h78);
    check("pin_e4m3_three", 32'(model_quant(1, 120, {1'b0, 8'd128, 23'h400000})), 32'h7C);
    check("pin_e4m3_neg_one", 32'(model_quant(1, 120, {1'b1, 8'd127, 23'd0})), 32'hF0);
    check("pin_e4m3_sat", 32'(model_quant(1, 119, {1'b0, 8'd128, 23'd0})), 32'h7E);
    check("pin_e2m1_four", 32'(model_quant(5, 127, {1'b0, 8'd129, 23'd0})), 32'h6);
`ifdef MX_ENC_RNE_EN
    check("pin_e2m1_tie", 32'(model_quant(5, 127, {1'b0, 8'd127, 23'h600000})), 32'h4);
`else
    check("pin_e2m1_tie", 32'(model_quant(5, 127, {1'b0, 8'd127, 23'h600000})), 32'h3);
`endif
    check("pin_e2m1_sub", 32'(model_quant(5, 127, {1'b0, 8'd126, 23'd0})), 32'h1);
    check("pin_int8_one", 32'(model_quant(0, 127, {1'b0, 8'd127, 23'd0})), 32'h40);
    check("pin_int8_neg_one", 32'(model_quant(0, 127, {1'b1, 8'd127, 23'd0})), 32'hC0);
    for (int i = 0; i < BLK; i++) blk_w[i] = {1'b0, 8'd127, 23'd0};
    check("pin_scale_e4m3", 32'(model_scale(1, nan)), 32'd119);

    // All +1.0 in E4M3.
    send_block(2'b01, 2'b10, 1'b0);
    check("lat_scale_cycle", 32'(out_valid), 32'd0);
    @(posedge clk_i);
    #1;
    check("lat_first_valid", 32'(out_valid), 32'd1);
    drain();
    check("t1_scale", 32'(out_scale), 32'd119);

    // 3.0 / -1.0 mix in E4M3.
    for (int i = 0; i < BLK; i++) blk_w[i] = {1'b0, 8'd127, 23'd0};
    blk_w[0] = {1'b0, 8'd128, 23'h400000};
    blk_w[5] = {1'b1, 8'd127, 23'd0};
    send_block(2'b01, 2'b10, 1'b0);
    drain();
    check("t2_scale", 32'(out_scale), 32'd120);

    // E2M1 with rounding-sensitive 1.75 and zeros.
    for (int i = 0; i < BLK; i++) blk_w[i] = 32'd0;
    blk_w[0] = {1'b0, 8'd129, 23'd0};
    blk_w[1] = {1'b0, 8'd127, 23'h600000};
    send_block(2'b11, 2'b00, 1'b0);
    drain();
    check("t3_scale", 32'(out_scale), 32'd127);

    // INT8, then the same block poisoned by exp 255.
    for (int i = 0; i < BLK; i++) blk_w[i] = {1'b0, 8'd127, 23'd0};
    send_block(2'b00, 2'b00, 1'b0);
    drain();
    check("t4_scale", 32'(out_scale), 32'd127);
    blk_w[3][30:23] = 8'hFF;
    send_block(2'b00, 2'b00, 1'b0);
    drain();
    check("t4_nan_scale", 32'(out_scale), 32'hFF);

    // Backpressure: out_ready high one cycle in three.
    ready_mode = 1;
    fill_random(140, 1'b0);
    send_block(2'b01, 2'b11, 1'b0);
    drain();
    ready_mode = 0;

    // Reset in the middle of collection.
    fill_random(100, 1'b0);
    for (int i = 0; i < 10; i++) send_elem(blk_w[i]);
    in_valid = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    fill_random(60, 1'b0);
    send_block(2'b01, 2'b01, 1'b0);
    drain();

    // Reset while emitting drops out_valid without waiting for a clock.
    fill_random(200, 1'b0);
    send_block(2'b01, 2'b00, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("emitrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk_i);
    #3 rst_i = 1'b0;

    // Randomized blocks over all formats, gaps and output stalls.
    for (int b = 0; b < 30; b++) begin
      ready_mode = int'($urandom_range(0, 2));
      fill_random((b % 5 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 254)), 1'b1);
      send_block(2'($urandom), 2'($urandom), 1'b1);
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mx_block_encoder.md
Name: mx_block_encoder

Overview:
- Converts a stream of FP32 values, typically accumulator results from the lvl2 adder tree, back into an MX block.
- Output is one shared E8M0 scale plus BLK narrow elements in the selected format (INT8, E4M3, E5M2, E3M2, E2M3, E2M1).
- Sits between the tensor-core accumulators and writeback; it is the encode side matching the decode/accumulate path.
- Single-buffered: it collects a full block, derives the scale, then emits the elements.

Parameters:
- BLK, 32, elements per MX block (power of 2, 2..64).
- CNT_W, $clog2(BLK), index counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- prec_mode  in  2  precision select, same encoding as adder tree (00 INT8, 01 FP8/FP6, 11 FP4).
- FP_mode  in  2  format select within prec_mode 01 (10 E4M3, 11 E5M2, 01 E3M2, 00 E2M3).
- in_valid  in  1  input element valid.
- in_ready  out  1  encoder accepts input.
- in_sign  in  1  FP32 sign.
- in_exp  in  8  FP32 biased exponent.
- in_mant  in  23  FP32 fraction.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  8  encoded element, right-justified, upper bits zero.
- out_scale  out  8  E8M0 shared scale, constant for the whole block.
- out_first  out  1  first element of the block.
- out_last  out  1  last element of the block.

Behaviour:
- Reset values:
  - state=COLLECT, idx=0, max_exp=0, nan_flag=0.
  - in_ready=1, out_valid=0, out_data=0, out_scale=0, out_first=0, out_last=0.
- COLLECT:
  - in_ready=1. Each in_valid&in_ready beat stores {sign,exp,mant} in buf[idx] and increments idx.
  - max_exp is updated incrementally: max_exp=max(max_exp,in_exp), ignoring exp 255. An exp of 255 sets nan_flag.
  - prec_mode/FP_mode are latched on the beat with idx=0.
  - The beat with idx=BLK-1 moves to SCALE and clears idx.
- SCALE, one cycle, in_ready=0:
  - Element emax: INT8 0, E4M3 8, E5M2 15, E3M2 4, E2M3 2, E2M1 2.
  - scale = nan_flag ? 255 : (max_exp==0 ? 0 : clamp(max_exp-emax, 0, 254)).
  - Register scale into out_scale, then go to EMIT.
- EMIT:
  - in_ready=0. out_data=quant(buf[idx]). out_first=(idx==0), out_last=(idx==BLK-1).
  - out_valid is held with data stable until out_ready.
  - On the out_valid&out_ready beat with idx=BLK-1: return to COLLECT, then clear max_exp, nan_flag and idx.
  - First input of the next block can be accepted the cycle after that final output beat.
  - Latency from last input accepted to first out_valid is 2 cycles.
- quant(v) operates on x = v * 2^-(scale-127):
  - FP32 in_exp==0 (zero/denormal) encodes as +0.
  - nan_flag=1 makes every element 0.
  - FP formats: normal and subnormal element encodings are produced. |x| above max finite saturates to max finite with sign preserved:
    - E4M3: 0x7E (448).
    - E5M2: 0x7B (57344).
    - E3M2: 0x1F (28).
    - E2M3: 0x1F (7.5).
    - E2M1: 0x7 (6).
  - Sign is the MSB of the element width.
  - INT8: two's complement fixed point 1.6 (value = code/64), saturated to ±127. Magnitude underflow gives 0.
  - Rounding follows the Optional Feature.
- Boundaries:
  - Changes to prec_mode/FP_mode mid-block are ignored.
  - in_valid outside COLLECT is ignored (not stored).
  - rst_i mid-block discards buffer and state immediately, and out_valid drops asynchronously.
  - out_ready stalls of any length are supported with no data loss.

Optional Feature:
- MX_ENC_RNE_EN:
  - Defined: quantization rounds to nearest, ties to even, and round-up overflow is then saturated.
  - Undefined: quantization truncates toward zero, and the round-increment logic is removed.
  - Scale computation is identical either way.

Test Plan:
- E4M3 (01/10), 32× +1.0 (exp 127, mant 0) -> out_scale=119, all out_data=0x78, first/last on beats 0/31.
- E4M3, element0=3.0 (exp 128, mant 0x400000), rest 1.0, element5=-1.0 -> scale=120, e0=0x7C, others=0x70, e5=0xF0.
- E2M1 (11), e0=4.0 (exp 129), e1=1.75 (exp 127, mant 0x600000), rest 0 -> scale=127, e0=0x6, e1=0x4 with RNE / 0x3 without, rest 0x0.
- INT8 (00), 32× +1.0 -> scale=127, data=0x40. Same block with e3 exp=255 -> scale=0xFF, all data 0x00.
- Backpressure: out_ready toggled 1-of-3 cycles during EMIT -> 32 beats, order and values unchanged, in_ready=0 throughout. Next block is accepted the cycle after out_last.
- rst_i asserted after 10 inputs -> out_valid=0, in_ready=1. A fresh 32-element block then encodes correctly with no residue.
